// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side bundle of the VGA raster sequencer: colour source in, raster position,
// sync and gated colour pins out.
interface vga_timing_ctrl_if;
  logic [3:0] red_in;
  logic [3:0] green_in;
  logic [3:0] blue_in;
  logic       pix_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       pix_req;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (
    input  red_in, green_in, blue_in,
    output pix_tick, x, y, pix_req, frame_start, hsync, vsync, red, green, blue
  );

  modport slave (
    output red_in, green_in, blue_in,
    input  pix_tick, x, y, pix_req, frame_start, hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-clock divider, h/v counters, registered sync and
// colour outputs that lag the presented x/y by one pixel period.
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clock,
  input  logic              res,
  vga_timing_ctrl_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST  = 10'(V_TOTAL - 1);

  // Region bounds are 11 bits so an end bound equal to 1024 still compares correctly.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [3:0]       red_q, red_d;
  logic [3:0]       green_q, green_d;
  logic [3:0]       blue_q, blue_d;

  logic pix_tick;
  logic active;
  logic hs_region;
  logic vs_region;
  logic h_wrap;
  logic v_wrap;

  assign pix_tick  = (div_q == DIV_MAX);
  assign h_wrap    = (h_cnt_q == H_LAST);
  assign v_wrap    = (v_cnt_q == V_LAST);
  assign active    = ({1'b0, h_cnt_q} < H_ACT) && ({1'b0, v_cnt_q} < V_ACT);
  assign hs_region = ({1'b0, h_cnt_q} >= HS_BEG) && ({1'b0, h_cnt_q} < HS_END);
  assign vs_region = ({1'b0, v_cnt_q} >= VS_BEG) && ({1'b0, v_cnt_q} < VS_END);

  always_comb begin
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;

    if (pix_tick) begin
      div_d = '0;
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // Output stage samples the pixel being retired, so sync and colour stay aligned.
      hsync_d = hs_region ? SYNC_POL : SYNC_IDLE;
      vsync_d = vs_region ? SYNC_POL : SYNC_IDLE;
      red_d   = active ? vif.red_in   : 4'h0;
      green_d = active ? vif.green_in : 4'h0;
      blue_d  = active ? vif.blue_in  : 4'h0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign vif.pix_tick    = pix_tick;
  assign vif.x           = h_cnt_q;
  assign vif.y           = v_cnt_q;
  assign vif.pix_req     = active;
  assign vif.frame_start = pix_tick && h_wrap && v_wrap;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.red         = red_q;
  assign vif.green       = green_q;
  assign vif.blue        = blue_q;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster sequencer for the VGA output path. Divides the board clock into a pixel tick, runs the horizontal and vertical counters, and generates registered hsync/vsync. Gates the pixel colour source onto the 4-bit-per-channel red/green/blue pins, forcing black outside the active area. It sits between any pixel generator, which consumes `x`/`y`/`pix_req`, and the VGA connector.

## Interface
Parameters:
- `CLK_DIV`, 4: board clocks per pixel, ≥1 (100 MHz → 25 MHz)
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `SYNC_POL`, 0: asserted sync level (0 = active-low)

Ports:
- `clock`  in  1  board clock; all logic rises on it
- `res`  in  1  asynchronous, active-low reset
- `red_in`/`green_in`/`blue_in`  in  4 each  pixel colour for current `x`,`y`
- `pix_tick`  out  1  one-clock pulse per pixel period
- `x`  out  10  current h_cnt
- `y`  out  10  current v_cnt
- `pix_req`  out  1  1 while (`x`,`y`) is in the active area
- `frame_start`  out  1  one-clock pulse as counters wrap to (0,0)
- `hsync`/`vsync`  out  1 each  registered sync outputs
- `red`/`green`/`blue`  out  4 each  registered colour outputs

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Both totals must be ≤1024. Counters are 10-bit unsigned.
- Divider: `div` counts 0..CLK_DIV-1 and wraps.
- `pix_tick` = 1 exactly when div == CLK_DIV-1. With CLK_DIV=1 it is constantly 1 out of reset.
- On each pix_tick edge, h_cnt increments, wrapping H_TOTAL-1 → 0.
- When h_cnt wraps, v_cnt increments, wrapping V_TOTAL-1 → 0.
- No other events change the counters.
- Regions:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE
  - hs_region = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs_region = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491)
- `x`/`y` = h_cnt/v_cnt. `pix_req` = active, decoded combinationally from the counters.
- Output stage updates only on pix_tick edges:
  - hsync ← hs_region ? SYNC_POL : ~SYNC_POL
  - vsync ← vs_region ? SYNC_POL : ~SYNC_POL
  - rgb ← active ? rgb_in : 0
- All three use the pre-increment counter values.
- `frame_start` = pix_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1.
- Reset (res = 0, asynchronous, any time including mid-line):
  - div, h_cnt and v_cnt = 0
  - hsync = vsync = ~SYNC_POL
  - red/green/blue = 0
- After res deasserts, the raster restarts cleanly at (0,0). No partial sync pulse is emitted.

## Timing
- Pixel period = CLK_DIV clocks.
- The first pix_tick is high during the CLK_DIV-th clock after res rises (div 0..CLK_DIV-1).
- Upstream contract: rgb_in must be valid for the current `x`,`y` at the pix_tick edge that ends that pixel period.
- The upstream generator has CLK_DIV clocks to respond.
- Output latency: pins show pixel (x,y) one pixel period after x/y present it. Sync outputs carry the same one-period lag, so colour and sync stay aligned.
- Line = 800 ticks; frame = 525 lines = 420 000 ticks.
- hsync asserted for 96 consecutive ticks per line; vsync asserted for 2 whole lines.
- frame_start pulses exactly once per frame, coincident with a pix_tick.
- rgb_in is ignored outside the active area; pins carry 0 for the whole blanking interval.

## Test plan
- Reset values:
  - Stimulus: hold res=0 with rgb_in=4'hF.
  - Required: hsync=vsync=1, rgb=0, x=y=0, pix_tick=0.
  - Then release res: first pix_tick is on the 4th clock; x becomes 1 one clock later.
- Horizontal timing:
  - Stimulus: count pix_ticks from the falling edge of hsync to its rising edge.
  - Required: 96 ticks. Falling edge occurs on the tick after x=656 is presented; line period = 800 ticks = 3200 clocks.
- Frame timing:
  - Stimulus: measure the interval between frame_start pulses.
  - Required: 1 680 000 clocks. vsync low for exactly 1600 ticks, starting when y=490 is first sampled.
- Blanking:
  - Stimulus: rgb_in=4'hA constantly.
  - Required: rgb=A only for the 640×480 active pixels; 0 at x=640..799 and at y≥480.
  - Required: `pix_req` matches active on every cycle.
- Reset mid-operation:
  - Stimulus: assert res for 1 clock at x=700, y=491, while hsync and vsync are both low.
  - Required: both outputs go high asynchronously; counters restart at 0,0 with full line and frame timing.
- CLK_DIV=1 build:
  - Required: pix_tick stays high after reset; line = 800 clocks; frame_start period = 420 000 clocks.
